// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the MIPS16-style instruction encoder:
// mnemonic codes, opcode/funct fields, error codes and immediate classes.
package instr_encoder_pkg;

  typedef enum logic [7:0] {
    OP_ADDU, OP_SUBU, OP_ADDIU, OP_ADDSP3, OP_CMPI, OP_BEQZ, OP_BNEZ, OP_LW_SP,
    OP_SW_SP, OP_LI, OP_ADDIU3, OP_ADDSP, OP_BTEQZ, OP_MTSP, OP_AND, OP_OR,
    OP_CMP, OP_NOT, OP_SLT, OP_JR, OP_MFPC, OP_JALR, OP_B, OP_LW,
    OP_SW, OP_SLL, OP_SRA, OP_MFIN, OP_MTIN, OP_INT, OP_NOP
  } op_e;

  typedef enum logic [2:0] {
    IMM_S4, IMM_S5, IMM_S8, IMM_S11, IMM_Z8, IMM_SH3, IMM_Z4, IMM_NONE
  } imm_class_e;

  typedef enum logic [1:0] {ST_IDLE, ST_ENC, ST_WRITE} state_e;

  localparam logic [4:0] OPC_ADDSP3 = 5'b00000;
  localparam logic [4:0] OPC_NOP    = 5'b00001;
  localparam logic [4:0] OPC_B      = 5'b00010;
  localparam logic [4:0] OPC_BEQZ   = 5'b00100;
  localparam logic [4:0] OPC_BNEZ   = 5'b00101;
  localparam logic [4:0] OPC_SHIFT  = 5'b00110;
  localparam logic [4:0] OPC_ADDIU3 = 5'b01000;
  localparam logic [4:0] OPC_ADDIU  = 5'b01001;
  localparam logic [4:0] OPC_I8     = 5'b01100;
  localparam logic [4:0] OPC_LI     = 5'b01101;
  localparam logic [4:0] OPC_CMPI   = 5'b01110;
  localparam logic [4:0] OPC_LW_SP  = 5'b10010;
  localparam logic [4:0] OPC_LW     = 5'b10011;
  localparam logic [4:0] OPC_SW_SP  = 5'b11010;
  localparam logic [4:0] OPC_SW     = 5'b11011;
  localparam logic [4:0] OPC_RRR    = 5'b11100;
  localparam logic [4:0] OPC_RR     = 5'b11101;
  localparam logic [4:0] OPC_MFMT   = 5'b11110;
  localparam logic [4:0] OPC_INT    = 5'b11111;

  localparam logic [1:0] FN_ADDU = 2'b01;
  localparam logic [1:0] FN_SUBU = 2'b11;
  localparam logic [1:0] FN_SLL  = 2'b00;
  localparam logic [1:0] FN_SRA  = 2'b11;
  localparam logic [1:0] FN_MFIN = 2'b00;
  localparam logic [1:0] FN_MTIN = 2'b01;

  localparam logic [4:0] F5_AND = 5'b01100;
  localparam logic [4:0] F5_OR  = 5'b01101;
  localparam logic [4:0] F5_CMP = 5'b01010;
  localparam logic [4:0] F5_NOT = 5'b01111;
  localparam logic [4:0] F5_SLT = 5'b00010;

  // Sub-selectors that occupy the rx/ry slot of the I8 and RR groups.
  localparam logic [2:0] SEL_BTEQZ = 3'b000;
  localparam logic [2:0] SEL_ADDSP = 3'b011;
  localparam logic [2:0] SEL_MTSP  = 3'b100;
  localparam logic [2:0] SEL_JR    = 3'b000;
  localparam logic [2:0] SEL_MFPC  = 3'b010;
  localparam logic [2:0] SEL_JALR  = 3'b110;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  function automatic logic imm_in_range(input imm_class_e cls, input int v);
    case (cls)
      IMM_S4:  return (v >= -8)    && (v <= 7);
      IMM_S5:  return (v >= -16)   && (v <= 15);
      IMM_S8:  return (v >= -128)  && (v <= 127);
      IMM_S11: return (v >= -1024) && (v <= 1023);
      IMM_Z8:  return (v >= 0)     && (v <= 255);
      IMM_SH3: return (v >= 1)     && (v <= 8);
      IMM_Z4:  return (v >= 0)     && (v <= 15);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: mnemonic + fields -> 16-bit word, with illegal-op and
// immediate range flags. Unused register fields never reach the word.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [2:0]  rx,
  input  logic [2:0]  ry,
  input  logic [2:0]  rz,
  input  logic [15:0] imm,
  output logic [15:0] word,
  output logic        illegal,
  output logic        range_err
);

  imm_class_e cls;

  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    word    = '0;
    cls     = IMM_NONE;
    illegal = 1'b0;
    case (op)
      OP_ADDU:   word = {OPC_RRR, rx, ry, rz, FN_ADDU};
      OP_SUBU:   word = {OPC_RRR, rx, ry, rz, FN_SUBU};
      OP_ADDIU:  begin word = {OPC_ADDIU,  rx, imm[7:0]}; cls = IMM_S8; end
      OP_ADDSP3: begin word = {OPC_ADDSP3, rx, imm[7:0]}; cls = IMM_S8; end
      OP_CMPI:   begin word = {OPC_CMPI,   rx, imm[7:0]}; cls = IMM_S8; end
      OP_BEQZ:   begin word = {OPC_BEQZ,   rx, imm[7:0]}; cls = IMM_S8; end
      OP_BNEZ:   begin word = {OPC_BNEZ,   rx, imm[7:0]}; cls = IMM_S8; end
      OP_LW_SP:  begin word = {OPC_LW_SP,  rx, imm[7:0]}; cls = IMM_S8; end
      OP_SW_SP:  begin word = {OPC_SW_SP,  rx, imm[7:0]}; cls = IMM_S8; end
      OP_LI:     begin word = {OPC_LI,     rx, imm[7:0]}; cls = IMM_Z8; end
      OP_ADDIU3: begin word = {OPC_ADDIU3, rx, ry, 1'b0, imm[3:0]}; cls = IMM_S4; end
      OP_ADDSP:  begin word = {OPC_I8, SEL_ADDSP, imm[7:0]}; cls = IMM_S8; end
      OP_BTEQZ:  begin word = {OPC_I8, SEL_BTEQZ, imm[7:0]}; cls = IMM_S8; end
      OP_MTSP:   word = {OPC_I8, SEL_MTSP, ry, 5'b00000};
      OP_AND:    word = {OPC_RR, rx, ry, F5_AND};
      OP_OR:     word = {OPC_RR, rx, ry, F5_OR};
      OP_CMP:    word = {OPC_RR, rx, ry, F5_CMP};
      OP_NOT:    word = {OPC_RR, rx, ry, F5_NOT};
      OP_SLT:    word = {OPC_RR, rx, ry, F5_SLT};
      OP_JR:     word = {OPC_RR, rx, SEL_JR,   5'b00000};
      OP_MFPC:   word = {OPC_RR, rx, SEL_MFPC, 5'b00000};
      OP_JALR:   word = {OPC_RR, rx, SEL_JALR, 5'b00000};
      OP_B:      begin word = {OPC_B, imm[10:0]}; cls = IMM_S11; end
      OP_LW:     begin word = {OPC_LW, rx, ry, imm[4:0]}; cls = IMM_S5; end
      OP_SW:     begin word = {OPC_SW, rx, ry, imm[4:0]}; cls = IMM_S5; end
      // A shift of 8 truncates to 3'b000, which is exactly its encoding.
      OP_SLL:    begin word = {OPC_SHIFT, rx, ry, imm[2:0], FN_SLL}; cls = IMM_SH3; end
      OP_SRA:    begin word = {OPC_SHIFT, rx, ry, imm[2:0], FN_SRA}; cls = IMM_SH3; end
      OP_MFIN:   word = {OPC_MFMT, rx, 6'b000000, FN_MFIN};
      OP_MTIN:   word = {OPC_MFMT, rx, 6'b000000, FN_MTIN};
      OP_INT:    begin word = {OPC_INT, 7'b0000000, imm[3:0]}; cls = IMM_Z4; end
      OP_NOP:    word = {OPC_NOP, 11'b0};
      default:   illegal = 1'b1;
    endcase
  end

  assign range_err = !illegal && !imm_in_range(cls, int'($signed(imm)));

endmodule

// File: rtl/instr_encoder.sv
// Accepts symbolic instructions, encodes them and writes the words to
// instruction memory at consecutive addresses over a write/ack handshake.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_op,
  input  logic [2:0]        in_rx,
  input  logic [2:0]        in_ry,
  input  logic [2:0]        in_rz,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  input  logic              mem_ack,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [15:0]       word_count,
  output logic              busy
);

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [2:0]        rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
  logic [15:0]       imm_q, imm_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_data_q, mem_data_d;
  logic              in_ready_q, in_ready_d;
  logic              tmo_err_q, tmo_err_d;

  logic [15:0] pk_word;
  logic        pk_illegal, pk_range, enc_err;

  instr_pack u_pack (
    .op       (op_q),
    .rx       (rx_q),
    .ry       (ry_q),
    .rz       (rz_q),
    .imm      (imm_q),
    .word     (pk_word),
    .illegal  (pk_illegal),
    .range_err(pk_range)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    rz_d       = rz_q;
    imm_d      = imm_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    tmo_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The pointer load and a same-cycle accept combine: the word lands at base_addr.
        if (base_load) ptr_d = base_addr;
        if (in_valid && in_ready_q) begin
          op_d    = in_op;
          rx_d    = in_rx;
          ry_d    = in_ry;
          rz_d    = in_rz;
          imm_d   = in_imm;
          state_d = ST_ENC;
        end
      end
      ST_ENC: begin
        tmo_d = '0;
        if (pk_illegal || pk_range) begin
          state_d = ST_IDLE;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr_q;
          mem_data_d = pk_word;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          mem_we_d = 1'b0;
          ptr_d    = ptr_q + ADDR_W'(1);
          cnt_d    = cnt_q + 16'd1;
          state_d  = ST_IDLE;
        end else if ((ACK_TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
          mem_we_d  = 1'b0;
          tmo_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      rz_q       <= '0;
      imm_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      in_ready_q <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      rz_q       <= rz_d;
      imm_q      <= imm_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      in_ready_q <= in_ready_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  // Encode errors are flagged during ENC itself; the timeout pulse follows the mem_we drop.
  assign enc_err = (state_q == ST_ENC) && (pk_illegal || pk_range);

  always_comb begin
    err_code = ERR_NONE;
    if (tmo_err_q)    err_code = ERR_TIMEOUT;
    else if (enc_err) err_code = pk_illegal ? ERR_ILLEGAL : ERR_RANGE;
  end

  assign err_valid  = enc_err || tmo_err_q;
  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign word_count = cnt_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder against a table-driven
// reference encoder and a pointer/count scoreboard.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int ACK_TIMEOUT = 4;
  localparam int NEVER       = -1;
  localparam int N_OPS       = 31;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        base_load = 1'b0;
  logic [15:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_op = '0;
  logic [2:0]  in_rx = '0, in_ry = '0, in_rz = '0;
  logic [15:0] in_imm = '0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ack = 1'b0;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] word_count;
  logic        busy;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(16), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .base_load (base_load),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rx     (in_rx),
    .in_ry     (in_ry),
    .in_rz     (in_rz),
    .in_imm    (in_imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack),
    .err_valid (err_valid),
    .err_code  (err_code),
    .word_count(word_count),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;
  int exp_ptr = 0;
  int exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each mnemonic is a fixed base word plus fields placed by arithmetic.
  typedef enum int {F_RRR, F_RXS8, F_RXZ8, F_RRS4, F_S8, F_RY, F_RX, F_RR,
                    F_S11, F_RRS5, F_SH, F_Z4, F_NONE} fmt_e;
  int   base_t[N_OPS];
  fmt_e fmt_t[N_OPS];

  task automatic set_op(input op_e op, input int base, input fmt_e f);
    base_t[int'(op)] = base;
    fmt_t[int'(op)]  = f;
  endtask

  task automatic init_table();
    set_op(OP_ADDU,   'hE001, F_RRR);  set_op(OP_SUBU,   'hE003, F_RRR);
    set_op(OP_ADDIU,  'h4800, F_RXS8); set_op(OP_ADDSP3, 'h0000, F_RXS8);
    set_op(OP_CMPI,   'h7000, F_RXS8); set_op(OP_BEQZ,   'h2000, F_RXS8);
    set_op(OP_BNEZ,   'h2800, F_RXS8); set_op(OP_LW_SP,  'h9000, F_RXS8);
    set_op(OP_SW_SP,  'hD000, F_RXS8); set_op(OP_LI,     'h6800, F_RXZ8);
    set_op(OP_ADDIU3, 'h4000, F_RRS4); set_op(OP_ADDSP,  'h6300, F_S8);
    set_op(OP_BTEQZ,  'h6000, F_S8);   set_op(OP_MTSP,   'h6400, F_RY);
    set_op(OP_AND,    'hE80C, F_RR);   set_op(OP_OR,     'hE80D, F_RR);
    set_op(OP_CMP,    'hE80A, F_RR);   set_op(OP_NOT,    'hE80F, F_RR);
    set_op(OP_SLT,    'hE802, F_RR);   set_op(OP_JR,     'hE800, F_RX);
    set_op(OP_MFPC,   'hE840, F_RX);   set_op(OP_JALR,   'hE8C0, F_RX);
    set_op(OP_B,      'h1000, F_S11);  set_op(OP_LW,     'h9800, F_RRS5);
    set_op(OP_SW,     'hD800, F_RRS5); set_op(OP_SLL,    'h3000, F_SH);
    set_op(OP_SRA,    'h3003, F_SH);   set_op(OP_MFIN,   'hF000, F_RX);
    set_op(OP_MTIN,   'hF001, F_RX);   set_op(OP_INT,    'hF800, F_Z4);
    set_op(OP_NOP,    'h0800, F_NONE);
  endtask

  function automatic int wrap(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  task automatic ref_encode(input int op, input int rx, input int ry, input int rz,
                            input int imm, output int word, output int err);
    int lo, hi;
    fmt_e f;
    word = 0;
    err  = 0;
    if (op < 0 || op >= N_OPS) begin
      err = 1;
    end else begin
      f  = fmt_t[op];
      lo = -32768;
      hi = 32767;
      case (f)
        F_RRS4:       begin lo = -8;    hi = 7;    end
        F_RRS5:       begin lo = -16;   hi = 15;   end
        F_RXS8, F_S8: begin lo = -128;  hi = 127;  end
        F_S11:        begin lo = -1024; hi = 1023; end
        F_RXZ8:       begin lo = 0;     hi = 255;  end
        F_SH:         begin lo = 1;     hi = 8;    end
        F_Z4:         begin lo = 0;     hi = 15;   end
        default: ;
      endcase
      if (imm < lo || imm > hi) begin
        err = 2;
      end else begin
        word = base_t[op];
        case (f)
          F_RRR:          word += rx * 256 + ry * 32 + rz * 4;
          F_RXS8, F_RXZ8: word += rx * 256 + wrap(imm, 256);
          F_RRS4:         word += rx * 256 + ry * 32 + wrap(imm, 16);
          F_S8:           word += wrap(imm, 256);
          F_RY:           word += ry * 32;
          F_RX:           word += rx * 256;
          F_RR:           word += rx * 256 + ry * 32;
          F_S11:          word += wrap(imm, 2048);
          F_RRS5:         word += rx * 256 + ry * 32 + wrap(imm, 32);
          F_SH:           word += rx * 256 + ry * 32 + wrap(imm, 8) * 4;
          F_Z4:           word += imm;
          default: ;
        endcase
      end
    end
  endtask

  task automatic load_base(input int addr);
    base_load = 1'b1;
    base_addr = 16'(addr);
    tick();
    base_load = 1'b0;
    exp_ptr = addr;
  endtask

  // Issue one request and follow it to completion; ack_dly = WRITE cycles without ack.
  task automatic do_req(input string tag, input int op, input int rx, input int ry,
                        input int rz, input int imm, input int ack_dly,
                        input bit load = 1'b0, input int load_addr = 0);
    int exp_word, exp_err, waitc;
    ref_encode(op, rx, ry, rz, imm, exp_word, exp_err);
    in_op = 8'(op); in_rx = 3'(rx); in_ry = 3'(ry); in_rz = 3'(rz); in_imm = 16'(imm);
    in_valid = 1'b1;
    base_load = load;
    base_addr = 16'(load_addr);
    waitc = 0;
    while (!in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    check({tag, "/ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    base_load = 1'b0;
    if (load) exp_ptr = load_addr;
    check({tag, "/enc_busy"}, 32'(busy), 32'd1);
    check({tag, "/enc_ready"}, 32'(in_ready), 32'd0);
    if (exp_err != 0) begin
      check({tag, "/err_valid"}, 32'(err_valid), 32'd1);
      check({tag, "/err_code"}, 32'(err_code), 32'(exp_err));
      check({tag, "/enc_we"}, 32'(mem_we), 32'd0);
      tick();
      check({tag, "/err_drop"}, 32'(err_valid), 32'd0);
      check({tag, "/err_we"}, 32'(mem_we), 32'd0);
      check({tag, "/err_cnt"}, 32'(word_count), 32'(exp_cnt));
      check({tag, "/err_idle"}, 32'(busy), 32'd0);
    end else begin
      check({tag, "/no_err"}, 32'(err_valid), 32'd0);
      tick();
      check({tag, "/we"}, 32'(mem_we), 32'd1);
      check({tag, "/addr"}, 32'(mem_addr), 32'(exp_ptr));
      check({tag, "/data"}, 32'(mem_data), 32'(exp_word));
      check({tag, "/wr_ready"}, 32'(in_ready), 32'd0);
      if (ack_dly < 0) begin
        for (int i = 1; i < ACK_TIMEOUT; i++) begin
          tick();
          check({tag, "/tmo_we_held"}, 32'(mem_we), 32'd1);
        end
        tick();
        check({tag, "/tmo_we_drop"}, 32'(mem_we), 32'd0);
        check({tag, "/tmo_err"}, 32'(err_valid), 32'd1);
        check({tag, "/tmo_code"}, 32'(err_code), 32'd3);
        check({tag, "/tmo_cnt"}, 32'(word_count), 32'(exp_cnt));
        tick();
        check({tag, "/tmo_pulse"}, 32'(err_valid), 32'd0);
      end else begin
        for (int i = 0; i < ack_dly; i++) begin
          tick();
          check({tag, "/hold_we"}, 32'(mem_we), 32'd1);
          check({tag, "/hold_data"}, 32'(mem_data), 32'(exp_word));
          check({tag, "/hold_addr"}, 32'(mem_addr), 32'(exp_ptr));
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        exp_ptr = (exp_ptr + 1) % 65536;
        exp_cnt = (exp_cnt + 1) % 65536;
        check({tag, "/done_we"}, 32'(mem_we), 32'd0);
        check({tag, "/done_cnt"}, 32'(word_count), 32'(exp_cnt));
        check({tag, "/done_ready"}, 32'(in_ready), 32'd1);
        check({tag, "/done_err"}, 32'(err_valid), 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op, imm, sel;
    int edges [21] = '{-1025, -1024, -129, -128, -17, -16, -9, -8, 0, 1, 7,
                       8, 9, 15, 16, 127, 128, 255, 256, 1023, 1024};
    init_table();

    rst = 1'b1;
    tick();
    tick();
    check("rst/we", 32'(mem_we), 32'd0);
    check("rst/addr", 32'(mem_addr), 32'd0);
    check("rst/data", 32'(mem_data), 32'd0);
    check("rst/ready", 32'(in_ready), 32'd0);
    check("rst/err", 32'(err_valid), 32'd0);
    check("rst/code", 32'(err_code), 32'd0);
    check("rst/cnt", 32'(word_count), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("rst/ready_rise", 32'(in_ready), 32'd1);

    load_base('h0100);
    do_req("addu", int'(OP_ADDU), 1, 2, 3, 0, 0);
    check("addu/cnt1", 32'(word_count), 32'd1);

    do_req("li", int'(OP_LI), 3, 0, 0, 255, 0);
    do_req("addiu", int'(OP_ADDIU), 0, 0, 0, -1, 1);
    do_req("b", int'(OP_B), 0, 0, 0, -1024, 0);
    do_req("sll8", int'(OP_SLL), 1, 2, 0, 8, 0);
    do_req("lw", int'(OP_LW), 2, 4, 0, -16, 2);
    do_req("addiu3_rng", int'(OP_ADDIU3), 1, 1, 0, 8, 0);
    check("addiu3/ptr_kept", 32'(exp_ptr), 32'h0106);

    load_base('hFFFF);
    do_req("nop_ffff", int'(OP_NOP), 5, 6, 7, 0, 3);
    do_req("nop_wrap", int'(OP_NOP), 0, 0, 0, 0, 3);

    do_req("bad_op", 255, 0, 0, 0, 0, 0);
    do_req("timeout", int'(OP_NOP), 0, 0, 0, 0, NEVER);
    do_req("after_tmo", int'(OP_INT), 0, 0, 0, 15, 0);
    do_req("load_and_req", int'(OP_MTSP), 7, 5, 3, 0, 0, 1'b1, 'h1234);

    // Reset lands in the second WRITE cycle: the in-flight word must vanish.
    in_op = 8'(OP_ADDU); in_rx = 3'd1; in_ry = 3'd1; in_rz = 3'd1; in_imm = '0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("rstw/we_before", 32'(mem_we), 32'd1);
    rst = 1'b1;
    tick();
    check("rstw/we", 32'(mem_we), 32'd0);
    check("rstw/cnt", 32'(word_count), 32'd0);
    check("rstw/busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();
    check("rstw/ready", 32'(in_ready), 32'd1);
    exp_ptr = 0;
    exp_cnt = 0;
    do_req("rstw/ptr0", int'(OP_JALR), 4, 7, 7, 0, 0);

    for (int n = 0; n < 80; n++) begin
      op  = int'($urandom_range(0, N_OPS + 4));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       imm = int'($urandom_range(0, 24)) - 12;
        1:       imm = int'($urandom_range(0, 300)) - 20;
        2:       imm = int'($urandom_range(0, 2100)) - 1050;
        default: imm = edges[$urandom_range(0, 20)];
      endcase
      do_req("rand", op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), imm, int'($urandom_range(0, ACK_TIMEOUT - 1)),
             ($urandom_range(0, 9) == 0), int'($urandom_range(0, 65535)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
